// File: rtl/eq_bist_pkg_amisha.sv
// Shared types and default parameters for the equality-comparator BIST engine.
package eq_bist_pkg_amisha;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        CHECK,
        DONE
    } bist_state_e;

    localparam int DEF_WIDTH      = 1;
    localparam int DEF_SETTLE_CYC = 1;
    localparam int DEF_ERR_W      = 8;

endpackage

// File: rtl/sat_counter_amisha.sv
// Saturating incrementer with synchronous clear; holds at all-ones, never wraps.
module sat_counter_amisha #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] value
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value = cnt_q;

endmodule

// File: rtl/eq_bist_checker_amisha.sv
// BIST engine: sweeps every operand pair into an equality comparator and
// checks its eq output against a golden a==b after a settle window.
module eq_bist_checker_amisha
    import eq_bist_pkg_amisha::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int ERR_W      = DEF_ERR_W
) (
    input  logic             clk_amisha,
    input  logic             rst_n_amisha,
    input  logic             start_amisha,
    output logic [WIDTH-1:0] a_amisha,
    output logic [WIDTH-1:0] b_amisha,
    input  logic             eq_in_amisha,
    output logic             busy_amisha,
    output logic             done_amisha,
    output logic             pass_amisha,
    output logic [ERR_W-1:0] err_count_amisha,
    output logic [WIDTH-1:0] fail_a_amisha,
    output logic [WIDTH-1:0] fail_b_amisha,
    output logic             fail_seen_amisha
);

    localparam int VW = 2 * WIDTH;
    localparam int SW = 4;

    bist_state_e      state_q, state_d;
    logic [VW-1:0]    vec_q, vec_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] fail_a_q, fail_a_d, fail_b_q, fail_b_d;
    logic             fail_seen_q, fail_seen_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             err_clr, err_inc, mismatch;
    logic [ERR_W-1:0] err_count;

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        settle_d    = settle_q;
        a_d         = a_q;
        b_d         = b_q;
        fail_a_d    = fail_a_q;
        fail_b_d    = fail_b_q;
        fail_seen_d = fail_seen_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        err_clr     = 1'b0;
        err_inc     = 1'b0;
        mismatch    = eq_in_amisha ^ (a_q == b_q);

        unique case (state_q)
            IDLE, DONE: begin
                if (start_amisha) begin
                    state_d     = DRIVE;
                    vec_d       = '0;
                    err_clr     = 1'b1;
                    fail_seen_d = 1'b0;
                    fail_a_d    = '0;
                    fail_b_d    = '0;
                    pass_d      = 1'b0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                end
            end
            DRIVE: begin
                a_d      = vec_q[VW-1:WIDTH];
                b_d      = vec_q[WIDTH-1:0];
                settle_d = SW'(SETTLE_CYC);
                state_d  = SETTLE;
            end
            SETTLE: begin
                settle_d = settle_q - SW'(1);
                if (settle_q == SW'(1)) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (mismatch) begin
                    err_inc = 1'b1;
                    if (!fail_seen_q) begin
                        fail_seen_d = 1'b1;
                        fail_a_d    = a_q;
                        fail_b_d    = b_q;
                    end
                end
                // Last vector: pass must also account for this final compare
                if (vec_q == '1) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_count == '0) && !mismatch;
                end else begin
                    vec_d   = vec_q + VW'(1);
                    state_d = DRIVE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
        if (!rst_n_amisha) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            settle_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            fail_a_q    <= '0;
            fail_b_q    <= '0;
            fail_seen_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            settle_q    <= settle_d;
            a_q         <= a_d;
            b_q         <= b_d;
            fail_a_q    <= fail_a_d;
            fail_b_q    <= fail_b_d;
            fail_seen_q <= fail_seen_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
        end
    end

    sat_counter_amisha #(
        .W(ERR_W)
    ) u_err_cnt (
        .clk  (clk_amisha),
        .rst_n(rst_n_amisha),
        .clr  (err_clr),
        .inc  (err_inc),
        .value(err_count)
    );

    assign a_amisha         = a_q;
    assign b_amisha         = b_q;
    assign busy_amisha      = busy_q;
    assign done_amisha      = done_q;
    assign pass_amisha      = pass_q;
    assign err_count_amisha = err_count;
    assign fail_a_amisha    = fail_a_q;
    assign fail_b_amisha    = fail_b_q;
    assign fail_seen_amisha = fail_seen_q;

endmodule

// File: tb/tb_eq_bist_checker_amisha.sv
// Randomized scoreboard bench: a behavioural comparator under test with
// selectable faults feeds the BIST; a monitor checks each completed sweep.
module tb_eq_bist_checker_amisha;

    localparam int W    = 2;
    localparam int S    = 3;
    localparam int E    = 3;
    localparam int NV   = 1 << (2 * W);
    localparam int PER  = S + 2;
    localparam int EMAX = (1 << E) - 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         eq_in;
    logic [W-1:0] a, b, fa, fb;
    logic         busy, done, pass, fs;
    logic [E-1:0] ec;

    always #5 clk = ~clk;

    eq_bist_checker_amisha #(
        .WIDTH(W),
        .SETTLE_CYC(S),
        .ERR_W(E)
    ) dut (
        .clk_amisha      (clk),
        .rst_n_amisha    (rst_n),
        .start_amisha    (start),
        .a_amisha        (a),
        .b_amisha        (b),
        .eq_in_amisha    (eq_in),
        .busy_amisha     (busy),
        .done_amisha     (done),
        .pass_amisha     (pass),
        .err_count_amisha(ec),
        .fail_a_amisha   (fa),
        .fail_b_amisha   (fb),
        .fail_seen_amisha(fs)
    );

    // comparator under test: 0 good, 1 stuck-0, 2 inverted, 3 flip mask, 4 delayed
    int          mode = 0;
    int          dly_n = 1;
    logic [15:0] mask = '0;
    logic [3:0]  dly = 4'hF;

    always @(posedge clk) dly <= {dly[2:0], a == b};

    always_comb begin
        eq_in = (a == b);
        case (mode)
            1: eq_in = 1'b0;
            2: eq_in = !(a == b);
            3: eq_in = (a == b) ^ mask[{a, b}];
            4: eq_in = dly[dly_n-1];
            default: eq_in = (a == b);
        endcase
    end

    typedef struct {
        int pass;
        int err;
        int fs;
        int fa;
        int fb;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // What eq value the comparator shows at the end of each settle window
    function automatic exp_t ref_model(input int m, input int d, input logic [15:0] mk);
        exp_t r;
        int   cnt = 0;
        r.fs = 0;
        r.fa = 0;
        r.fb = 0;
        for (int k = 0; k < NV; k++) begin
            int av = k / (1 << W);
            int bv = k % (1 << W);
            int gold = (av == bv) ? 1 : 0;
            int pk = (k == 0) ? 0 : k - 1;
            int seen;
            case (m)
                1: seen = 0;
                2: seen = 1 - gold;
                3: seen = gold ^ int'(mk[k]);
                4: begin
                    if (d <= S) seen = gold;
                    else if (k == 0) seen = 1;
                    else seen = ((pk / (1 << W)) == (pk % (1 << W))) ? 1 : 0;
                end
                default: seen = gold;
            endcase
            if (seen != gold) begin
                cnt++;
                if (r.fs == 0) begin
                    r.fs = 1;
                    r.fa = av;
                    r.fb = bv;
                end
            end
        end
        r.err  = (cnt > EMAX) ? EMAX : cnt;
        r.pass = (cnt == 0) ? 1 : 0;
        r.cyc  = NV * PER;
        return r;
    endfunction

    // Monitor: one pop per rising done
    initial begin
        int   cyc = 0;
        logic done_p = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cyc    = 0;
                done_p = 1'b0;
            end else begin
                if (busy === 1'b1) cyc++;
                if (done === 1'b1 && !done_p) begin
                    if (q.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("pass", int'(pass), e.pass);
                        chk("err_count", int'(ec), e.err);
                        chk("fail_seen", int'(fs), e.fs);
                        chk("fail_a", int'(fa), e.fa);
                        chk("fail_b", int'(fb), e.fb);
                        chk("busy_cycles", cyc, e.cyc);
                        chk("busy_at_done", int'(busy), 0);
                        chk("a_hold", int'(a), (1 << W) - 1);
                        chk("b_hold", int'(b), (1 << W) - 1);
                    end
                    cyc = 0;
                end
                done_p = (done === 1'b1);
            end
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_pass"}, int'(pass), 0);
        chk({tag, "_err"}, int'(ec), 0);
        chk({tag, "_fs"}, int'(fs), 0);
        chk({tag, "_fa"}, int'(fa), 0);
        chk({tag, "_fb"}, int'(fb), 0);
        chk({tag, "_a"}, int'(a), 0);
        chk({tag, "_b"}, int'(b), 0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (done !== 1'b1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (done !== 1'b1) chk({tag, "_timeout"}, 0, 1);
    endtask

    task automatic sweep(input int m, input int d, input bit extra);
        @(negedge clk);
        mode  = m;
        dly_n = d;
        mask  = 16'($urandom);
        repeat (6) @(negedge clk);
        q.push_back(ref_model(m, d, mask));
        pulse_start();
        if (extra) begin
            repeat ($urandom_range(2, 60)) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done("sweep");
        repeat ($urandom_range(2, 5)) @(negedge clk);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        @(negedge clk);
        #2 rst_n = 1'b1;

        sweep(0, 1, 1'b0);
        sweep(1, 1, 1'b0);
        sweep(2, 1, 1'b0);
        sweep(3, 1, 1'b0);
        sweep(4, 3, 1'b0);
        sweep(4, 4, 1'b0);
        sweep(0, 1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            sweep($urandom_range(0, 4), $urandom_range(1, 4), 1'($urandom_range(0, 1)));
        end

        // reset mid-sweep: nothing survives, next sweep is clean
        @(negedge clk);
        mode = 2;
        pulse_start();
        repeat ($urandom_range(10, 70)) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero("midreset");
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        sweep(0, 1, 1'b0);
        sweep(3, 1, 1'b1);

        repeat (4) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
